// File: rtl/jt900h_div.sv
// Multi-cycle restoring divider for DIV/DIVS (16/8 byte form, 32/16 word form).
// Result packs quotient low and remainder high; v flags overflow, /0 or illegal width.
module jt900h_div #(
  parameter int BPC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        start,
  input  logic        sgn,
  input  logic [2:0]  w,
  input  logic [31:0] op0,
  input  logic [31:0] op1,
  output logic        busy,
  output logic        done,
  output logic        v,
  output logic [31:0] rslt
);

  typedef enum logic [1:0] {IDLE, PREP, ITER, POST} state_t;

  localparam logic [3:0] LAST_BYTE = 4'(8 / BPC - 1);
  localparam logic [3:0] LAST_WORD = 4'(16 / BPC - 1);

  state_t      state_q, state_d;
  logic [31:0] op0_q, op0_d;
  logic [15:0] op1_q, op1_d;
  logic        sgn_q, sgn_d;
  logic        word_q, word_d;
  logic        ill_q, ill_d;
  logic [16:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rslt_q, rslt_d;
  logic        v_q, v_d;

  // Operand conditioning, evaluated while in PREP
  logic [31:0] dvd_raw, dvd_neg, dvd_mag;
  logic [15:0] dvs_raw, dvs_neg, dvs_mag, dvd_hi;
  logic        dvd_sgn, dvs_sgn, prep_err;

  always_comb begin
    dvd_raw  = word_q ? op0_q : {16'h0000, op0_q[15:0]};
    dvd_sgn  = sgn_q & (word_q ? op0_q[31] : op0_q[15]);
    dvd_neg  = ~dvd_raw + 32'd1;
    dvd_mag  = dvd_sgn ? (word_q ? dvd_neg : {16'h0000, dvd_neg[15:0]}) : dvd_raw;
    dvs_raw  = word_q ? op1_q : {8'h00, op1_q[7:0]};
    dvs_sgn  = sgn_q & (word_q ? op1_q[15] : op1_q[7]);
    dvs_neg  = ~dvs_raw + 16'd1;
    dvs_mag  = dvs_sgn ? (word_q ? dvs_neg : {8'h00, dvs_neg[7:0]}) : dvs_raw;
    dvd_hi   = word_q ? dvd_mag[31:16] : {8'h00, dvd_mag[15:8]};
    prep_err = ill_q | (dvs_raw == 16'h0000) | (dvd_hi >= dvs_mag);
  end

  // Byte quotients sit left-aligned in quo_q so the MSB feeding rem is always bit 15
  logic [16:0] step_rem;
  logic [15:0] step_quo;

  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    for (int i = 0; i < BPC; i++) begin
      step_rem = {step_rem[15:0], step_quo[15]};
      step_quo = {step_quo[14:0], 1'b0};
      if (step_rem >= {1'b0, dvs_q}) begin
        step_rem    = step_rem - {1'b0, dvs_q};
        step_quo[0] = 1'b1;
      end
    end
  end

  // Sign fix and signed range check on the final iteration's values
  logic [15:0] quo_s, rem_s, half;
  logic        ovf;
  logic [31:0] packed_r;

  always_comb begin
    quo_s    = qneg_q ? (~step_quo + 16'd1) : step_quo;
    rem_s    = rneg_q ? (~step_rem[15:0] + 16'd1) : step_rem[15:0];
    half     = word_q ? 16'h8000 : 16'h0080;
    ovf      = sgn_q & ((step_quo > half) | ((step_quo == half) & ~qneg_q));
    packed_r = word_q ? {rem_s, quo_s} : {op0_q[31:16], rem_s[7:0], quo_s[7:0]};
  end

  always_comb begin
    state_d = state_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    sgn_d   = sgn_q;
    word_d  = word_q;
    ill_d   = ill_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    rslt_d  = rslt_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op0_d   = op0;
          op1_d   = op1[15:0];
          sgn_d   = sgn;
          word_d  = w[1];
          ill_d   = w[2];
          state_d = PREP;
        end
      end
      PREP: begin
        if (prep_err) begin
          rslt_d  = op0_q;
          v_d     = 1'b1;
          state_d = POST;
        end else begin
          rem_d   = {1'b0, dvd_hi};
          quo_d   = word_q ? dvd_mag[15:0] : {dvd_mag[7:0], 8'h00};
          dvs_d   = dvs_mag;
          qneg_d  = dvd_sgn ^ dvs_sgn;
          rneg_d  = dvd_sgn;
          cnt_d   = 4'd0;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == (word_q ? LAST_WORD : LAST_BYTE)) begin
          rslt_d  = ovf ? op0_q : packed_r;
          v_d     = ovf;
          state_d = POST;
        end
      end
      POST: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op0_q   <= '0;
      op1_q   <= '0;
      sgn_q   <= 1'b0;
      word_q  <= 1'b0;
      ill_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      rslt_q  <= '0;
      v_q     <= 1'b0;
    end else if (cen) begin
      state_q <= state_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
      sgn_q   <= sgn_d;
      word_q  <= word_d;
      ill_q   <= ill_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      rslt_q  <= rslt_d;
      v_q     <= v_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == POST);
  assign v    = v_q;
  assign rslt = rslt_q;

  // Bits with no role: divisor upper half, byte flag (byte is implied), rem carry bit
  logic unused_bits;
  assign unused_bits = &{1'b0, op1[31:16], w[0], step_rem[16]};

endmodule

// File: tb/tb_jt900h_div.sv
// Directed bench for jt900h_div: checks BPC=1 and BPC=2 instances side by side
// on hand-computed quotient/remainder vectors, latencies, reset abort and cen gating.
module tb_jt900h_div;

  logic        clk = 1'b0;
  logic        rst, cen, start, sgn;
  logic [2:0]  w;
  logic [31:0] op0, op1;
  logic        busy1, done1, v1, busy2, done2, v2;
  logic [31:0] rslt1, rslt2;

  int passed = 0;
  int total  = 0;

  logic [31:0] res1, res2;
  logic        vv1, vv2;
  int          lat1, lat2;

  always #5 clk = ~clk;

  jt900h_div #(.BPC(1)) u_dut1 (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .sgn(sgn), .w(w),
    .op0(op0), .op1(op1), .busy(busy1), .done(done1), .v(v1), .rslt(rslt1)
  );

  jt900h_div #(.BPC(2)) u_dut2 (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .sgn(sgn), .w(w),
    .op0(op0), .op1(op1), .busy(busy2), .done(done2), .v(v2), .rslt(rslt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one start and counts cen=1 cycles until each instance shows done
  task automatic run_op(input logic s, input logic [2:0] ww, input logic [31:0] a,
                        input logic [31:0] b, input bit rnd);
    int  cnt;
    bit  got1, got2;
    @(negedge clk);
    sgn = s; w = ww; op0 = a; op1 = b; start = 1'b1; cen = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; got1 = 0; got2 = 0; lat1 = 999; lat2 = 999;
    res1 = 'x; res2 = 'x; vv1 = 1'bx; vv2 = 1'bx;
    for (int k = 0; k < 300 && !(got1 && got2); k++) begin
      if (k > 0) @(negedge clk);
      cen = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cen) begin
        cnt++;
        if (done1 && !got1) begin got1 = 1; lat1 = cnt; res1 = rslt1; vv1 = v1; end
        if (done2 && !got2) begin got2 = 1; lat2 = cnt; res2 = rslt2; vv2 = v2; end
      end
    end
    cen = 1'b1;
  endtask

  task automatic op_check(input string tag, input logic s, input logic [2:0] ww,
                          input logic [31:0] a, input logic [31:0] b, input bit rnd,
                          input logic [31:0] er, input logic ev, input int el1, input int el2);
    run_op(s, ww, a, b, rnd);
    $display("op %s: sgn=%0b w=%b op0=%h op1=%h -> r1=%h v1=%0b lat1=%0d r2=%h v2=%0b lat2=%0d",
             tag, s, ww, a, b, res1, vv1, lat1, res2, vv2, lat2);
    check({tag, ".rslt1"}, res1, er);
    check({tag, ".v1"}, {31'd0, vv1}, {31'd0, ev});
    check({tag, ".lat1"}, lat1, el1);
    check({tag, ".rslt2"}, res2, er);
    check({tag, ".v2"}, {31'd0, vv2}, {31'd0, ev});
    check({tag, ".lat2"}, lat2, el2);
    @(negedge clk);
    check({tag, ".idle"}, {28'd0, busy1, busy2, done1, done2}, 32'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; cen = 1'b1; start = 1'b0; sgn = 1'b0; w = 3'b001; op0 = '0; op1 = '0;
    repeat (3) @(negedge clk);
    check("rst.flags", {28'd0, busy1, done1, v1, busy2}, 32'd0);
    check("rst.rslt1", rslt1, 32'd0);
    check("rst.rslt2", {rslt2[31:1], v2}, 32'd0);
    rst = 1'b0;

    op_check("div_b",    1'b0, 3'b001, 32'hABCD0064, 32'h00000007, 0, 32'hABCD020E, 1'b0, 10, 6);
    op_check("div_w",    1'b0, 3'b010, 32'h000186A0, 32'h00000100, 0, 32'h00A00186, 1'b0, 18, 10);
    op_check("divs_b",   1'b1, 3'b001, 32'h0000FF9C, 32'h00000007, 0, 32'h0000FEF2, 1'b0, 10, 6);
    op_check("divs_nd",  1'b1, 3'b001, 32'h00000064, 32'hDEAD00F9, 0, 32'h000002F2, 1'b0, 10, 6);
    op_check("div_zero", 1'b0, 3'b001, 32'h00001234, 32'h00000000, 0, 32'h00001234, 1'b1, 2, 2);
    op_check("hi_ovf",   1'b0, 3'b001, 32'h00000800, 32'h00000004, 0, 32'h00000800, 1'b1, 2, 2);
    op_check("divs_ovf", 1'b1, 3'b001, 32'h00000080, 32'h00000001, 0, 32'h00000080, 1'b1, 10, 6);
    op_check("divs_min", 1'b1, 3'b001, 32'h0000FF80, 32'h00000001, 0, 32'h00000080, 1'b0, 10, 6);
    op_check("divs_w",   1'b1, 3'b010, 32'hFFFFFF9C, 32'h0000FFF9, 0, 32'hFFFE000E, 1'b0, 18, 10);
    op_check("illegal",  1'b0, 3'b100, 32'h55AA55AA, 32'h00000003, 0, 32'h55AA55AA, 1'b1, 2, 2);
    op_check("div_wmax", 1'b0, 3'b010, 32'hFFFE0001, 32'h0000FFFF, 0, 32'h0000FFFF, 1'b0, 18, 10);
    op_check("div_bmax", 1'b0, 3'b001, 32'h0000FE01, 32'h000000FF, 0, 32'h000000FF, 1'b0, 10, 6);

    // Reset in the middle of a word divide: abort with no done pulse
    @(negedge clk);
    sgn = 1'b0; w = 3'b010; op0 = 32'h000186A0; op1 = 32'h00000100; start = 1'b1; cen = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("abort: busy1=%0b busy2=%0b done1=%0b done2=%0b rslt1=%h", busy1, busy2, done1, done2, rslt1);
    check("abort.flags", {28'd0, busy1, busy2, done1, done2}, 32'd0);
    check("abort.rslt1", rslt1, 32'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done1 || done2 || busy1 || busy2) seen++;
    end
    check("abort.quiet", seen, 0);

    op_check("post_rst", 1'b0, 3'b001, 32'hABCD0064, 32'h00000007, 0, 32'hABCD020E, 1'b0, 10, 6);
    op_check("cen_b",    1'b0, 3'b001, 32'hABCD0064, 32'h00000007, 1, 32'hABCD020E, 1'b0, 10, 6);
    op_check("cen_w",    1'b0, 3'b010, 32'h000186A0, 32'h00000100, 1, 32'h00A00186, 1'b0, 18, 10);
    op_check("cen_divs", 1'b1, 3'b001, 32'h0000FF9C, 32'h00000007, 1, 32'h0000FEF2, 1'b0, 10, 6);
    op_check("cen_zero", 1'b0, 3'b001, 32'h00001234, 32'h00000000, 1, 32'h00001234, 1'b1, 2, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
